// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator control slice.
// Holds the travel direction encoding used by the car scheduler.
package elevator_pkg;

    typedef enum logic [1:0] {
        DIR_IDLE = 2'b00,
        DIR_UP   = 2'b01,
        DIR_DOWN = 2'b10
    } dir_t;

endpackage

// File: rtl/floor_priority_pick.sv
// Finds the lowest and highest set bit of a per-floor vector.
// A found flag qualifies both indices; they read 0 when the vector is empty.
module floor_priority_pick #(
    parameter int FLOORS  = 8,
    parameter int FLOOR_W = $clog2(FLOORS)
) (
    input  logic [FLOORS-1:0]  i_vec,
    output logic [FLOOR_W-1:0] o_lo_idx,
    output logic [FLOOR_W-1:0] o_hi_idx,
    output logic               o_found
);

    always_comb begin
        o_lo_idx = '0;
        o_hi_idx = '0;
        o_found  = |i_vec;
        // Scanning in opposite directions lets the last hit win in each loop.
        for (int i = FLOORS - 1; i >= 0; i--) begin
            if (i_vec[i]) o_lo_idx = FLOOR_W'(i);
        end
        for (int i = 0; i < FLOORS; i++) begin
            if (i_vec[i]) o_hi_idx = FLOOR_W'(i);
        end
    end

endmodule

// File: rtl/floor_request_scheduler.sv
// Pending hall/cabin call latch with service clearing and SCAN-style
// direction and target selection for a single elevator car.
module floor_request_scheduler
    import elevator_pkg::*;
#(
    parameter int FLOORS  = 8,
    parameter int FLOOR_W = $clog2(FLOORS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [FLOORS-1:0]  btn_num_in,
    input  logic [FLOORS-1:0]  btn_up_out,
    input  logic [FLOORS-1:0]  btn_down_out,
    input  logic [FLOOR_W-1:0] car_floor,
    input  logic               car_stopped,
    output logic [FLOORS-1:0]  active_in_levels,
    output logic [FLOORS-1:0]  active_out_up_levels,
    output logic [FLOORS-1:0]  active_out_down_levels,
    output logic [1:0]         dir,
    output logic               target_valid,
    output logic [FLOOR_W-1:0] target_floor
);

    // Top floor has no up button and ground floor has no down button.
    localparam logic [FLOORS-1:0] UP_BTN_MASK   = {1'b0, {(FLOORS-1){1'b1}}};
    localparam logic [FLOORS-1:0] DOWN_BTN_MASK = {{(FLOORS-1){1'b1}}, 1'b0};

    logic [FLOORS-1:0]  r_in;
    logic [FLOORS-1:0]  r_up;
    logic [FLOORS-1:0]  r_down;
    dir_t               r_dir;
    logic               r_target_valid;
    logic [FLOOR_W-1:0] r_target_floor;

    logic [31:0]        w_car_idx;
    logic [FLOORS-1:0]  w_above_mask;
    logic [FLOORS-1:0]  w_below_mask;
    logic [FLOORS-1:0]  w_car_onehot;
    logic               w_service;
    logic               w_any_above;
    logic               w_any_below;
    logic [FLOORS-1:0]  w_clr_in;
    logic [FLOORS-1:0]  w_clr_up;
    logic [FLOORS-1:0]  w_clr_down;
    logic [FLOORS-1:0]  w_next_in;
    logic [FLOORS-1:0]  w_next_up;
    logic [FLOORS-1:0]  w_next_down;
    dir_t               w_next_dir;
    logic               w_next_target_valid;
    logic [FLOOR_W-1:0] w_next_target_floor;

    logic [FLOOR_W-1:0] w_up_prim_lo,  w_up_prim_hi;
    logic [FLOOR_W-1:0] w_up_rev_lo,   w_up_rev_hi;
    logic [FLOOR_W-1:0] w_dn_prim_lo,  w_dn_prim_hi;
    logic [FLOOR_W-1:0] w_dn_rev_lo,   w_dn_rev_hi;
    logic               w_up_prim_found, w_up_rev_found;
    logic               w_dn_prim_found, w_dn_rev_found;
    logic               w_unused_pick;

    assign w_car_idx = 32'(car_floor);

    always_comb begin
        w_above_mask = '0;
        w_below_mask = '0;
        w_car_onehot = '0;
        for (int i = 0; i < FLOORS; i++) begin
            w_above_mask[i] = (32'(i) > w_car_idx);
            w_below_mask[i] = (32'(i) < w_car_idx);
            w_car_onehot[i] = (32'(i) == w_car_idx);
        end
    end

    // Travelling up: nearest call ahead that wants to go up, else the farthest down-call.
    floor_priority_pick #(.FLOORS(FLOORS), .FLOOR_W(FLOOR_W)) u_pick_up_prim (
        .i_vec    (w_above_mask & (r_in | r_up)),
        .o_lo_idx (w_up_prim_lo),
        .o_hi_idx (w_up_prim_hi),
        .o_found  (w_up_prim_found)
    );

    floor_priority_pick #(.FLOORS(FLOORS), .FLOOR_W(FLOOR_W)) u_pick_up_rev (
        .i_vec    (w_above_mask & r_down),
        .o_lo_idx (w_up_rev_lo),
        .o_hi_idx (w_up_rev_hi),
        .o_found  (w_up_rev_found)
    );

    floor_priority_pick #(.FLOORS(FLOORS), .FLOOR_W(FLOOR_W)) u_pick_dn_prim (
        .i_vec    (w_below_mask & (r_in | r_down)),
        .o_lo_idx (w_dn_prim_lo),
        .o_hi_idx (w_dn_prim_hi),
        .o_found  (w_dn_prim_found)
    );

    floor_priority_pick #(.FLOORS(FLOORS), .FLOOR_W(FLOOR_W)) u_pick_dn_rev (
        .i_vec    (w_below_mask & r_up),
        .o_lo_idx (w_dn_rev_lo),
        .o_hi_idx (w_dn_rev_hi),
        .o_found  (w_dn_rev_found)
    );

    assign w_unused_pick = ^{w_up_prim_hi, w_up_rev_lo, w_dn_prim_lo, w_dn_rev_hi};

    assign w_any_above = w_up_prim_found | w_up_rev_found;
    assign w_any_below = w_dn_prim_found | w_dn_rev_found;

    // A hall call is kept when the car will reverse away from it at this floor.
    assign w_service  = car_stopped && (w_car_idx < FLOORS);
    assign w_clr_in   = w_service ? w_car_onehot : '0;
    assign w_clr_up   = (w_service && ((r_dir != DIR_DOWN) || !w_any_below)) ? w_car_onehot : '0;
    assign w_clr_down = (w_service && ((r_dir != DIR_UP) || !w_any_above)) ? w_car_onehot : '0;

    assign w_next_in   = (r_in   | btn_num_in)                    & ~w_clr_in;
    assign w_next_up   = (r_up   | (btn_up_out & UP_BTN_MASK))    & ~w_clr_up;
    assign w_next_down = (r_down | (btn_down_out & DOWN_BTN_MASK)) & ~w_clr_down;

    always_comb begin
        w_next_dir          = DIR_IDLE;
        w_next_target_valid = 1'b0;
        w_next_target_floor = r_target_floor;

        case (r_dir)
            DIR_UP: begin
                if (w_any_above)      w_next_dir = DIR_UP;
                else if (w_any_below) w_next_dir = DIR_DOWN;
            end
            DIR_DOWN: begin
                if (w_any_below)      w_next_dir = DIR_DOWN;
                else if (w_any_above) w_next_dir = DIR_UP;
            end
            default: begin
                if (w_any_above)      w_next_dir = DIR_UP;
                else if (w_any_below) w_next_dir = DIR_DOWN;
            end
        endcase

        if (w_next_dir == DIR_UP) begin
            w_next_target_valid = 1'b1;
            w_next_target_floor = w_up_prim_found ? w_up_prim_lo : w_up_rev_hi;
        end else if (w_next_dir == DIR_DOWN) begin
            w_next_target_valid = 1'b1;
            w_next_target_floor = w_dn_prim_found ? w_dn_prim_hi : w_dn_rev_lo;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_in           <= '0;
            r_up           <= '0;
            r_down         <= '0;
            r_dir          <= DIR_IDLE;
            r_target_valid <= 1'b0;
            r_target_floor <= '0;
        end else begin
            r_in           <= w_next_in;
            r_up           <= w_next_up;
            r_down         <= w_next_down;
            r_dir          <= w_next_dir;
            r_target_valid <= w_next_target_valid;
            r_target_floor <= w_next_target_floor;
        end
    end

    assign active_in_levels       = r_in;
    assign active_out_up_levels   = r_up;
    assign active_out_down_levels = r_down;
    assign dir                    = r_dir;
    assign target_valid           = r_target_valid;
    assign target_floor           = r_target_floor;

endmodule

// File: tb/tb_floor_request_scheduler.sv
// Self-checking bench: directed elevator scenarios plus randomized traffic
// compared against a floor-by-floor behavioural model of the call rules.
module tb_floor_request_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] btnNum = '0, btnUp = '0, btnDown = '0;
    logic [2:0] carFloor = '0;
    logic       carStopped = 1'b0;
    logic [7:0] activeIn, activeUp, activeDown;
    logic [1:0] dirOut;
    logic       targetValid;
    logic [2:0] targetFloor;

    logic [5:0] btnNum6 = '0, btnUp6 = '0, btnDown6 = '0;
    logic [2:0] carFloor6 = '0;
    logic       carStopped6 = 1'b0;
    logic [5:0] activeIn6, activeUp6, activeDown6;
    logic [1:0] dirOut6;
    logic       targetValid6;
    logic [2:0] targetFloor6;

    int nAsserts = 0;
    int nFails   = 0;

    bit [7:0] mIn = '0, mUp = '0, mDown = '0;
    int       mDir = 0;
    bit       mTv = 1'b0;
    int       mTf = 0;

    always #5 clk = ~clk;

    floor_request_scheduler #(.FLOORS(8)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .btn_num_in             (btnNum),
        .btn_up_out             (btnUp),
        .btn_down_out           (btnDown),
        .car_floor              (carFloor),
        .car_stopped            (carStopped),
        .active_in_levels       (activeIn),
        .active_out_up_levels   (activeUp),
        .active_out_down_levels (activeDown),
        .dir                    (dirOut),
        .target_valid           (targetValid),
        .target_floor           (targetFloor)
    );

    floor_request_scheduler #(.FLOORS(6)) dut6 (
        .clk                    (clk),
        .reset                  (reset),
        .btn_num_in             (btnNum6),
        .btn_up_out             (btnUp6),
        .btn_down_out           (btnDown6),
        .car_floor              (carFloor6),
        .car_stopped            (carStopped6),
        .active_in_levels       (activeIn6),
        .active_out_up_levels   (activeUp6),
        .active_out_down_levels (activeDown6),
        .dir                    (dirOut6),
        .target_valid           (targetValid6),
        .target_floor           (targetFloor6)
    );

    task automatic modelReset();
        mIn = '0; mUp = '0; mDown = '0;
        mDir = 0; mTv = 1'b0; mTf = 0;
    endtask

    // Direction codes in the model: 0 idle, 1 up, 2 down.
    task automatic modelStep(input bit [7:0] bn, input bit [7:0] bu, input bit [7:0] bd,
                             input int cf, input bit stop);
        bit [7:0] pend, newIn, newUp, newDown;
        bit       above, below, found;
        int       nd;
        pend  = mIn | mUp | mDown;
        above = 1'b0;
        below = 1'b0;
        for (int f = 0; f < 8; f++) begin
            if (pend[f] && f > cf) above = 1'b1;
            if (pend[f] && f < cf) below = 1'b1;
        end
        newIn   = mIn | bn;
        newUp   = mUp | (bu & 8'h7F);
        newDown = mDown | (bd & 8'hFE);
        if (stop && cf < 8) begin
            newIn[cf] = 1'b0;
            if (mDir != 2 || !below) newUp[cf] = 1'b0;
            if (mDir != 1 || !above) newDown[cf] = 1'b0;
        end
        if (mDir == 2) nd = below ? 2 : (above ? 1 : 0);
        else           nd = above ? 1 : (below ? 2 : 0);
        found = 1'b0;
        if (nd == 1) begin
            for (int f = cf + 1; f < 8; f++)
                if (!found && (mIn[f] || mUp[f])) begin mTf = f; found = 1'b1; end
            for (int f = 7; f > cf; f--)
                if (!found && mDown[f]) begin mTf = f; found = 1'b1; end
        end else if (nd == 2) begin
            for (int f = cf - 1; f >= 0; f--)
                if (!found && (mIn[f] || mDown[f])) begin mTf = f; found = 1'b1; end
            for (int f = 0; f < cf; f++)
                if (!found && mUp[f]) begin mTf = f; found = 1'b1; end
        end
        mTv   = (nd != 0);
        mDir  = nd;
        mIn   = newIn;
        mUp   = newUp;
        mDown = newDown;
    endtask

    task automatic checkVal(input string name, input logic [31:0] observed, input logic [31:0] expected);
        nAsserts++;
        assert (observed === expected) else begin
            nFails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", name, observed, expected);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkVal({tag, " in"},   32'(activeIn),    32'(mIn));
        checkVal({tag, " up"},   32'(activeUp),    32'(mUp));
        checkVal({tag, " down"}, 32'(activeDown),  32'(mDown));
        checkVal({tag, " dir"},  32'(dirOut),      32'(mDir));
        checkVal({tag, " tv"},   32'(targetValid), 32'(mTv));
        checkVal({tag, " tf"},   32'(targetFloor), 32'(mTf));
    endtask

    task automatic applyStimulus(input logic [7:0] bn, input logic [7:0] bu, input logic [7:0] bd,
                                 input logic [2:0] cf, input logic stop, input logic rst);
        btnNum     = bn;
        btnUp      = bu;
        btnDown    = bd;
        carFloor   = cf;
        carStopped = stop;
        reset      = rst;
        @(posedge clk);
        if (rst) modelReset();
        else     modelStep(bn, bu, bd, int'(cf), stop);
        #1;
    endtask

    initial begin
        $display("[TB] start");

        // Reset held with every button pressed, then release with buttons still held.
        applyStimulus(8'hFF, 8'hFF, 8'hFF, 3'd0, 1'b1, 1'b1);
        checkOutput("rst1");
        applyStimulus(8'hFF, 8'hFF, 8'hFF, 3'd0, 1'b1, 1'b1);
        checkOutput("rst2");
        checkVal("rst in zero", 32'(activeIn), 32'h0);
        checkVal("rst dir idle", 32'(dirOut), 32'h0);
        applyStimulus(8'hFF, 8'hFF, 8'hFF, 3'd0, 1'b0, 1'b0);
        checkOutput("latch");
        checkVal("latch in", 32'(activeIn), 32'hFF);
        checkVal("latch up", 32'(activeUp), 32'h7F);
        checkVal("latch down", 32'(activeDown), 32'hFE);
        applyStimulus(8'h00, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1);
        checkOutput("rst3");

        // Single cabin call at floor 5 from floor 2.
        applyStimulus(8'h20, 8'h00, 8'h00, 3'd2, 1'b0, 1'b0);
        checkOutput("c5 set");
        checkVal("c5 in", 32'(activeIn), 32'h20);
        checkVal("c5 dir still idle", 32'(dirOut), 32'h0);
        applyStimulus(8'h00, 8'h00, 8'h00, 3'd2, 1'b0, 1'b0);
        checkOutput("c5 go");
        checkVal("c5 dir up", 32'(dirOut), 32'h1);
        checkVal("c5 tf", 32'(targetFloor), 32'd5);
        checkVal("c5 tv", 32'(targetValid), 32'h1);
        applyStimulus(8'h00, 8'h00, 8'h00, 3'd5, 1'b1, 1'b0);
        checkOutput("c5 serve");
        checkVal("c5 cleared", 32'(activeIn), 32'h0);
        applyStimulus(8'h00, 8'h00, 8'h00, 3'd5, 1'b0, 1'b0);
        checkOutput("c5 idle");
        checkVal("c5 idle dir", 32'(dirOut), 32'h0);
        checkVal("c5 tf hold", 32'(targetFloor), 32'd5);

        // Calls on both sides while heading up from floor 4.
        applyStimulus(8'h42, 8'h00, 8'h00, 3'd4, 1'b0, 1'b0);
        checkOutput("c61 set");
        applyStimulus(8'h00, 8'h00, 8'h00, 3'd4, 1'b0, 1'b0);
        checkOutput("c61 go");
        checkVal("c61 tf6", 32'(targetFloor), 32'd6);
        applyStimulus(8'h00, 8'h00, 8'h00, 3'd6, 1'b1, 1'b0);
        checkOutput("c61 serve6");
        checkVal("c61 dir down", 32'(dirOut), 32'h2);
        checkVal("c61 tf1", 32'(targetFloor), 32'd1);
        applyStimulus(8'h00, 8'h00, 8'h00, 3'd1, 1'b1, 1'b0);
        checkOutput("c61 serve1");

        // Down-calls at 3 and 6 seen from floor 1.
        applyStimulus(8'h00, 8'h00, 8'h48, 3'd1, 1'b0, 1'b0);
        checkOutput("d36 set");
        applyStimulus(8'h00, 8'h00, 8'h00, 3'd1, 1'b0, 1'b0);
        checkOutput("d36 go");
        checkVal("d36 dir up", 32'(dirOut), 32'h1);
        checkVal("d36 tf6", 32'(targetFloor), 32'd6);
        applyStimulus(8'h00, 8'h00, 8'h00, 3'd6, 1'b1, 1'b0);
        checkOutput("d36 serve6");
        checkVal("d36 down6 cleared", 32'(activeDown), 32'h08);
        checkVal("d36 dir down", 32'(dirOut), 32'h2);
        checkVal("d36 tf3", 32'(targetFloor), 32'd3);
        applyStimulus(8'h00, 8'h00, 8'h00, 3'd3, 1'b1, 1'b0);
        checkOutput("d36 serve3");

        // Clear beats set at the car floor; edge hall buttons do not exist.
        applyStimulus(8'h08, 8'h80, 8'h01, 3'd3, 1'b1, 1'b0);
        checkOutput("edge");
        checkVal("edge in3", 32'(activeIn), 32'h0);
        checkVal("edge up7", 32'(activeUp), 32'h0);
        checkVal("edge down0", 32'(activeDown), 32'h0);

        // Six-floor car reporting an out-of-range floor while stopped.
        btnNum6 = 6'h3F; btnUp6 = 6'h3F; btnDown6 = 6'h3F;
        carFloor6 = 3'd7; carStopped6 = 1'b1;
        applyStimulus(8'h00, 8'h00, 8'h00, 3'd3, 1'b0, 1'b0);
        checkOutput("f6 idle8");
        btnNum6 = '0; btnUp6 = '0; btnDown6 = '0;
        applyStimulus(8'h00, 8'h00, 8'h00, 3'd3, 1'b0, 1'b0);
        checkVal("f6 in kept", 32'(activeIn6), 32'h3F);
        checkVal("f6 up kept", 32'(activeUp6), 32'h1F);
        checkVal("f6 down kept", 32'(activeDown6), 32'h3E);
        checkVal("f6 dir down", 32'(dirOut6), 32'h2);
        checkVal("f6 tv", 32'(targetValid6), 32'h1);
        checkVal("f6 tf5", 32'(targetFloor6), 32'd5);
        carStopped6 = 1'b0;

        // Randomized traffic with occasional mid-travel resets.
        for (int n = 0; n < 400; n++) begin
            applyStimulus(8'($urandom & $urandom & $urandom),
                          8'($urandom & $urandom & $urandom),
                          8'($urandom & $urandom & $urandom),
                          3'($urandom_range(0, 7)),
                          ($urandom_range(0, 2) == 0),
                          ($urandom_range(0, 49) == 0));
            checkOutput("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
